alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 49 ++++
 rtl/alu_arbiter_alu.sv | 51 +++++
 rtl/alu_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared types for the two-port ALU arbiter: FSM states, ALU op codes,
// the registered-operation bundle and the round-robin grant helper.
package alu_arb_pkg;

    localparam int NREQ = 2;
    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_SLL  = 4'h2,
        ALU_SLT  = 4'h3,
        ALU_SLTU = 4'h4,
        ALU_XOR  = 4'h5,
        ALU_SR   = 4'h6,
        ALU_OR   = 4'h7,
        ALU_AND  = 4'h8
    } alu_op_e;

    typedef struct packed {
        logic [XLEN-1:0] src1;
        logic [XLEN-1:0] src2;
        logic [3:0]      ctrl;
        logic            ext;
        logic            addcom;
        logic            owner;
    } alu_req_t;

    // A lone requester wins; on contention the one not served last wins.
    function automatic logic [NREQ-1:0] rr_grant(
        input logic [NREQ-1:0] valid,
        input logic            last
    );
        logic [NREQ-1:0] g;
        if (valid == 2'b11) begin
            g = last ? 2'b01 : 2'b10;
        end else begin
            g = valid;
        end
        return g;
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared combinational ALU; addcom forces an add for immediate forms,
// ext selects arithmetic rather than logical right shift.
module alu
    import alu_arb_pkg::*;
(
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic [3:0]      ctrl_i,
    input  logic            ext_i,
    input  logic            addcom_i,
    output logic [XLEN-1:0] res_o,
    output logic            zero_o
);

    logic [4:0]             shamt;
    logic signed [XLEN-1:0] s1;
    logic signed [XLEN-1:0] s2;

    assign shamt = src2_i[4:0];
    assign s1    = $signed(src1_i);
    assign s2    = $signed(src2_i);

    always_comb begin
        res_o = '0;
        if (addcom_i) begin
            res_o = src1_i + src2_i;
        end else begin
            case (ctrl_i)
                ALU_ADD:  res_o = src1_i + src2_i;
                ALU_SUB:  res_o = src1_i - src2_i;
                ALU_SLL:  res_o = src1_i << shamt;
                ALU_SLT:  res_o = {31'b0, s1 < s2};
                ALU_SLTU: res_o = {31'b0, src1_i < src2_i};
                ALU_XOR:  res_o = src1_i ^ src2_i;
                ALU_SR: begin
                    if (ext_i) begin
                        res_o = s1 >>> shamt;
                    end else begin
                        res_o = src1_i >> shamt;
                    end
                end
                ALU_OR:   res_o = src1_i | src2_i;
                ALU_AND:  res_o = src1_i & src2_i;
                default:  res_o = '0;
            endcase
        end
    end

    assign zero_o = (res_o == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared ALU (IDLE/EXEC/RESP).
// ALU_ARB_FASTRSP_EN lets a new request be accepted while the response retires.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int PRIO_INIT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*XLEN-1:0] req_src1,
    input  logic [NREQ*XLEN-1:0] req_src2,
    input  logic [NREQ*4-1:0]    req_ctrl,
    input  logic [NREQ-1:0]      req_ext,
    input  logic [NREQ-1:0]      req_addcom,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [XLEN-1:0]      rsp_data,
    output logic                 rsp_zero,
    output logic                 busy
);

    // Pointer holds the last granted index, so reset it to the other one.
    localparam logic PTR_RST = (PRIO_INIT == 0) ? 1'b1 : 1'b0;

    state_e          state_q, state_d;
    logic            ptr_q, ptr_d;
    alu_req_t        op_q, op_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;
    logic            rsp_zero_q, rsp_zero_d;

    logic [NREQ-1:0] gnt;
    logic            gnt_idx;
    logic [NREQ-1:0] rdy;
    logic [NREQ-1:0] vld;
    logic            accept;
    logic [XLEN-1:0] alu_res;
    logic            alu_zero;

    assign gnt     = rr_grant(req_valid, ptr_q);
    assign gnt_idx = gnt[1];

    alu u_alu (
        .src1_i   (op_q.src1),
        .src2_i   (op_q.src2),
        .ctrl_i   (op_q.ctrl),
        .ext_i    (op_q.ext),
        .addcom_i (op_q.addcom),
        .res_o    (alu_res),
        .zero_o   (alu_zero)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        op_d       = op_q;
        rsp_data_d = rsp_data_q;
        rsp_zero_d = rsp_zero_q;
        rdy        = '0;
        vld        = '0;
        accept     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                rdy    = gnt;
                accept = |(req_valid & gnt);
                if (accept) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_data_d = alu_res;
                rsp_zero_d = alu_zero;
                state_d    = S_RESP;
            end
            S_RESP: begin
                vld[op_q.owner] = 1'b1;
                if (rsp_ready[op_q.owner]) begin
`ifdef ALU_ARB_FASTRSP_EN
                    rdy     = gnt;
                    accept  = |(req_valid & gnt);
                    state_d = accept ? S_EXEC : S_IDLE;
`else
                    state_d = S_IDLE;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (accept) begin
            ptr_d       = gnt_idx;
            op_d.owner  = gnt_idx;
            op_d.src1   = gnt_idx ? req_src1[63:32] : req_src1[31:0];
            op_d.src2   = gnt_idx ? req_src2[63:32] : req_src2[31:0];
            op_d.ctrl   = gnt_idx ? req_ctrl[7:4] : req_ctrl[3:0];
            op_d.ext    = req_ext[gnt_idx];
            op_d.addcom = req_addcom[gnt_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= PTR_RST;
            op_q       <= '0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            op_q       <= op_d;
            rsp_data_q <= rsp_data_d;
            rsp_zero_q <= rsp_zero_d;
        end
    end

    // Grant is combinational from req_valid, so mask it while in reset.
    assign req_ready = rst_n ? rdy : '0;
    assign rsp_valid = vld;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
    assign busy      = (state_q != S_IDLE);

endmodule
